// File: rtl/hex_display_pkg.sv
// Shared constants for the multiplexed hex display driver: segment widths,
// the hex-to-segment table and digit-count limits.
package hex_display_pkg;

    localparam int SEG_W      = 7;
    localparam int MAX_DIGITS = 8;

    typedef logic [3:0]       nibble_t;
    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;

    // Active-high segment patterns, bit order {d,e,f,a,b,c,g}; entry 15 is the MSB slice.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'b0111001,  // F
        7'b1111001,  // E
        7'b1100111,  // D
        7'b1111000,  // C
        7'b1110011,  // B
        7'b0111111,  // A
        7'b1011111,  // 9
        7'b1111111,  // 8
        7'b0001110,  // 7
        7'b1111011,  // 6
        7'b1011011,  // 5
        7'b0010111,  // 4
        7'b1001111,  // 3
        7'b1101101,  // 2
        7'b0000110,  // 1
        7'b1111110   // 0
    };

endpackage

// File: rtl/hex_seg_encode.sv
// Combinational hex nibble to active-high seven-segment pattern lookup.
module hex_seg_encode
    import hex_display_pkg::*;
(
    input  logic [3:0]       i_nibble,
    output logic [SEG_W-1:0] o_seg
);

    nibble_t w_nibble;

    assign w_nibble = i_nibble;
    assign o_seg    = SEG_TABLE[w_nibble];

endmodule

// File: rtl/hex_display_mux.sv
// Time-multiplexed hex display driver: snapshot register, refresh prescaler
// with one dead cycle per slot, leading-zero blanking and output polarity.
module hex_display_mux
    import hex_display_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 1024,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 1,
    parameter int BLANK_LEADING  = 1
)
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig
);

    if (DIGITS < 1 || DIGITS > MAX_DIGITS || REFRESH_DIV < 2) begin : g_bad_param
        $error("hex_display_mux: DIGITS must be 1..8 and REFRESH_DIV at least 2");
    end

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    localparam logic              SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic              DIG_INV = (DIG_ACTIVE_LOW != 0);
    localparam logic [SEG_W-1:0]  SEG_OFF = SEG_BLANK ^ {SEG_W{SEG_INV}};
    localparam logic [DIGITS-1:0] DIG_OFF = {DIGITS{DIG_INV}};

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_snap_data;
    logic [DIGITS-1:0]   r_snap_dp;
    logic [SEG_W-1:0]    r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_dig;

    logic                w_active;
    logic [3:0]          w_nib;
    logic                w_cur_dp;
    logic                w_cur_blank;
    logic                w_nz_above;
    logic [DIGITS-1:0]   w_blank;
    logic [SEG_W-1:0]    w_seg_raw;
    logic [SEG_W-1:0]    w_seg_lvl;
    logic                w_dp_lvl;
    logic [DIGITS-1:0]   w_dig_lvl;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_snap_data <= '0;
            r_snap_dp   <= '0;
        end else if (load) begin
            r_snap_data <= data;
            r_snap_dp   <= dp_in;
        end
    end

    // A digit is blank when it and every more significant nibble are zero;
    // scanning from the top lets one running OR cover all of them.
    always_comb begin
        w_nz_above = 1'b0;
        w_blank    = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_nz_above = w_nz_above | (r_snap_data[i*4 +: 4] != 4'h0);
            w_blank[i] = (BLANK_LEADING != 0) && (i != 0) && !w_nz_above;
        end
    end

    always_comb begin
        w_nib       = 4'h0;
        w_cur_dp    = 1'b0;
        w_cur_blank = 1'b0;
        w_dig_lvl   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib        = r_snap_data[i*4 +: 4];
                w_cur_dp     = r_snap_dp[i];
                w_cur_blank  = w_blank[i];
                w_dig_lvl[i] = w_active;
            end
        end
    end

    hex_seg_encode u_encode (
        .i_nibble (w_nib),
        .o_seg    (w_seg_raw)
    );

    assign w_active  = (r_cnt != '0);
    assign w_seg_lvl = (w_active && !w_cur_blank) ? w_seg_raw : SEG_BLANK;
    assign w_dp_lvl  = w_active && w_cur_dp;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_seg <= SEG_OFF;
            r_dp  <= SEG_INV;
            r_dig <= DIG_OFF;
        end else begin
            r_seg <= w_seg_lvl ^ {SEG_W{SEG_INV}};
            r_dp  <= w_dp_lvl ^ SEG_INV;
            r_dig <= w_dig_lvl ^ DIG_OFF;
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;
    assign dig = r_dig;

endmodule

// File: tb/tb_hex_display_mux.sv
// Bench for hex_display_mux: cycle scoreboard against a reference model, a
// table of decode vectors, and directed reset/load/polarity sequences.
module tb_hex_display_mux;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  dig;

    logic [3:0]  data2 = '0;
    logic [0:0]  dp_in2 = '0;
    logic        load2 = 1'b0;
    logic [6:0]  seg2;
    logic        dp2;
    logic [0:0]  dig2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hex_display_mux #(
        .DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1), .BLANK_LEADING(1)
    ) dut (
        .clk(clk), .resetn(resetn), .data(data), .dp_in(dp_in), .load(load),
        .seg(seg), .dp(dp), .dig(dig)
    );

    hex_display_mux #(
        .DIGITS(1), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0), .BLANK_LEADING(1)
    ) dut1 (
        .clk(clk), .resetn(resetn), .data(data2), .dp_in(dp_in2), .load(load2),
        .seg(seg2), .dp(dp2), .dig(dig2)
    );

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    typedef struct packed {
        logic [15:0]     d;
        logic [3:0]      dpi;
        logic [3:0][6:0] s;
        logic [3:0]      dpx;
    } vec_t;

    out_t exp_q[$];

    int          m_cnt = 0;
    int          m_idx = 0;
    logic [15:0] m_sd  = '0;
    logic [3:0]  m_sdp = '0;

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;  4'h1: return 7'b0000110;
            4'h2: return 7'b1101101;  4'h3: return 7'b1001111;
            4'h4: return 7'b0010111;  4'h5: return 7'b1011011;
            4'h6: return 7'b1111011;  4'h7: return 7'b0001110;
            4'h8: return 7'b1111111;  4'h9: return 7'b1011111;
            4'hA: return 7'b0111111;  4'hB: return 7'b1110011;
            4'hC: return 7'b1111000;  4'hD: return 7'b1100111;
            4'hE: return 7'b1111001;  default: return 7'b0111001;
        endcase
    endfunction

    function automatic out_t model_out(input int cnt, input int idx,
                                       input logic [15:0] sd, input logic [3:0] sdp);
        out_t       o;
        logic [3:0] oh;
        logic       blank;
        o.dig = 4'hF;
        o.seg = 7'b0;
        o.dp  = 1'b0;
        if (cnt != 0) begin
            oh    = 4'b1 << idx;
            o.dig = ~oh;
            blank = (idx > 0) && ((sd >> (idx * 4)) == 16'h0);
            o.seg = blank ? 7'b0 : ref_seg(sd[idx*4 +: 4]);
            o.dp  = sdp[idx];
        end
        return o;
    endfunction

    task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, x, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_idx = 0;
        m_sd  = '0;
        m_sdp = '0;
        exp_q.delete();
    endtask

    // One clock: drive at negedge, predict, clock, compare at next negedge.
    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dpi);
        out_t e;
        load  = ld;
        data  = d;
        dp_in = dpi;
        exp_q.push_back(model_out(m_cnt, m_idx, m_sd, m_sdp));
        @(posedge clk);
        if (ld) begin
            m_sd  = d;
            m_sdp = dpi;
        end
        if (m_cnt == 3) begin
            m_cnt = 0;
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_cnt++;
        end
        @(negedge clk);
        e = exp_q.pop_front();
        chk("sb_dig", 16'(dig), 16'(e.dig));
        chk("sb_seg", 16'(seg), 16'(e.seg));
        chk("sb_dp",  16'(dp),  16'(e.dp));
    endtask

    vec_t vecs[9];

    initial begin
        int              dead;
        logic [3:0]      seen;
        logic [3:0][6:0] os;
        logic [3:0]      odp;
        logic [3:0]      oh;
        int              act;
        bit              found;

        vecs[0] = '{16'h1A3F, 4'b0000, {7'b0000110, 7'b0111111, 7'b1001111, 7'b0111001}, 4'b0000};
        vecs[1] = '{16'h0007, 4'b0000, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0001110}, 4'b0000};
        vecs[2] = '{16'h0000, 4'b0000, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b0000};
        vecs[3] = '{16'h1234, 4'b0100, {7'b0000110, 7'b1101101, 7'b1001111, 7'b0010111}, 4'b0100};
        vecs[4] = '{16'h0000, 4'b0100, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b0100};
        vecs[5] = '{16'h8090, 4'b1001, {7'b1111111, 7'b1111110, 7'b1011111, 7'b1111110}, 4'b1001};
        vecs[6] = '{16'h00B0, 4'b0000, {7'b0000000, 7'b0000000, 7'b1110011, 7'b1111110}, 4'b0000};
        vecs[7] = '{16'hEDC5, 4'b1111, {7'b1111001, 7'b1100111, 7'b1111000, 7'b1011011}, 4'b1111};
        vecs[8] = '{16'h0006, 4'b0010, {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111011}, 4'b0010};

        // Reset held for three clocks
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dig", 16'(dig), 16'h000F);
        chk("rst_seg", 16'(seg), 16'h0000);
        chk("rst_dp",  16'(dp),  16'h0000);
        chk("rst1_dig", 16'(dig2), 16'h0000);
        chk("rst1_seg", 16'(seg2), 16'h007F);
        chk("rst1_dp",  16'(dp2),  16'h0001);
        model_reset();
        resetn = 1'b1;
        step(1'b0, 16'h0, 4'h0);
        chk("rel_dead_dig", 16'(dig), 16'h000F);
        step(1'b0, 16'h0, 4'h0);
        chk("rel_d0_dig", 16'(dig), 16'h000E);
        chk("rel_d0_seg", 16'(seg), 16'h007E);

        // Table of decode vectors, each observed over one full scan
        for (int n = 0; n < 9; n++) begin
            step(1'b1, vecs[n].d, vecs[n].dpi);
            dead = 0;
            seen = '0;
            os   = '0;
            odp  = '0;
            for (int k = 0; k < 16; k++) begin
                step(1'b0, vecs[n].d, vecs[n].dpi);
                if (dig == 4'hF) dead++;
                for (int i = 0; i < 4; i++) begin
                    oh = 4'b1 << i;
                    if (dig == ~oh) begin
                        seen[i] = 1'b1;
                        os[i]   = seg;
                        odp[i]  = dp;
                    end
                end
            end
            chk($sformatf("v%0d_dead", n), 16'(dead), 16'd4);
            chk($sformatf("v%0d_seen", n), 16'(seen), 16'h000F);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("v%0d_seg%0d", n, i), 16'(os[i]), 16'(vecs[n].s[i]));
                chk($sformatf("v%0d_dp%0d", n, i),  16'(odp[i]), 16'(vecs[n].dpx[i]));
            end
        end

        // Changing data without load must not disturb two full scans
        for (int k = 0; k < 32; k++) step(1'b0, 16'hFFFF, 4'hF);

        // Load pulse while digit 0 is mid-slot
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_cnt == 2 && m_idx == 0) found = 1'b1;
            else step(1'b0, 16'h4321, 4'h0);
        end
        chk("midslot_found", 16'(found), 16'h0001);
        chk("midslot_pre_dig", 16'(dig), 16'h000E);
        step(1'b1, 16'h0009, 4'h0);
        step(1'b0, 16'h0009, 4'h0);
        chk("midslot_dig", 16'(dig), 16'h000E);
        chk("midslot_seg", 16'(seg), 16'h005F);

        // Asynchronous reset while a digit is active
        step(1'b1, 16'h5555, 4'hF);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            step(1'b0, 16'h5555, 4'hF);
            if (dig != 4'hF) found = 1'b1;
        end
        chk("arst_found", 16'(found), 16'h0001);
        resetn = 1'b0;
        #1;
        chk("arst_dig", 16'(dig), 16'h000F);
        chk("arst_seg", 16'(seg), 16'h0000);
        chk("arst_dp",  16'(dp),  16'h0000);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step(1'b0, 16'h0, 4'h0);
        chk("arst_rel_dig", 16'(dig), 16'h000F);
        step(1'b0, 16'h0, 4'h0);
        chk("arst_d0_dig", 16'(dig), 16'h000E);
        chk("arst_d0_seg", 16'(seg), 16'h007E);
        chk("arst_d0_dp",  16'(dp),  16'h0000);

        // Single-digit, inverted-polarity instance
        load2 = 1'b1;
        data2 = 4'h8;
        step(1'b0, 16'h0, 4'h0);
        load2 = 1'b0;
        act  = 0;
        dead = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 16'h0, 4'h0);
            if (dig2 == 1'b1) begin
                act++;
                chk("v1_act_seg", 16'(seg2), 16'h0000);
            end else begin
                dead++;
                chk("v1_dead_seg", 16'(seg2), 16'h007F);
            end
            chk("v1_dp", 16'(dp2), 16'h0001);
        end
        chk("v1_act_cnt",  16'(act),  16'd6);
        chk("v1_dead_cnt", 16'(dead), 16'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hex_display_mux.md
# hex_display_mux

Parametrised multiplexed hex display driver: shows a DIGITS-wide hex word on a common-segment multi-digit seven-segment display by time-multiplexing the digit enables. It replaces the single-digit hex decoder at the top of display designs and adds:
- a snapshot register for tear-free updates,
- a refresh prescaler with anti-ghosting dead time,
- per-digit decimal points,
- leading-zero blanking,
- configurable output polarity.

## Interface
- DIGITS, 4: number of digits, legal range 1..8.
- REFRESH_DIV, 1024: clocks per digit slot, minimum 2.
- SEG_ACTIVE_LOW, 0: 1 inverts seg and dp (common-anode).
- DIG_ACTIVE_LOW, 1: 1 means a digit enable is asserted low.
- BLANK_LEADING, 1: 1 blanks leading zero digits.
- clk  in  1  system clock, all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- data  in  4*DIGITS  hex word; nibble i drives digit i, digit 0 is least significant.
- dp_in  in  DIGITS  decimal-point request per digit.
- load  in  1  when 1 at a clk edge, data and dp_in are captured into the snapshot.
- seg  out  7  segment drive. Bit order {d,e,f,a,b,c,g} = seg[6:0].
- dp  out  1  decimal-point drive.
- dig  out  DIGITS  one-hot digit enable.

## Operation
- **Snapshot.** On a load edge, snap_data <= data and snap_dp <= dp_in. The display reads only the snapshot. Without load the display holds indefinitely.
- **Prescaler.** cnt counts 0..REFRESH_DIV-1 and wraps. On the wrap, idx advances from 0 to DIGITS-1, then back to 0. With DIGITS=1, idx stays 0.
- **Dead time.** While cnt==0, all dig outputs are inactive, and seg and dp are the inactive level. For cnt 1..REFRESH_DIV-1, dig[idx] is active and all other digits are inactive.
- **Decode.** For an active slot, seg = encode(snap nibble idx) and dp = snap_dp[idx]. Encoding, active-high {d,e,f,a,b,c,g}:
  - 0=1111110, 1=0000110, 2=1101101, 3=1001111
  - 4=0010111, 5=1011011, 6=1111011, 7=0001110
  - 8=1111111, 9=1011111, A=0111111, B=1110011
  - C=1111000, D=1100111, E=1111001, F=0111001
- **Leading-zero blanking** (BLANK_LEADING=1):
  - Digit i>0 is blank when every snapshot nibble j>=i is 0.
  - Blank means seg is all inactive. dig is still scanned normally. dp still follows snap_dp.
  - Digit 0 is never blanked, so an all-zero word shows a single "0".
- **Polarity.** SEG_ACTIVE_LOW inverts seg and dp. DIG_ACTIVE_LOW inverts dig. Both are applied at the output register.
- **Reset (resetn=0), asynchronous:**
  - cnt=0, idx=0, snap_data=0, snap_dp=0.
  - seg, dp and dig are all driven to their inactive levels.
  - Reset mid-slot aborts the scan immediately. After release, the scan restarts at digit 0 with a dead-time cycle.
- **load during a slot.** A load during a digit's active slot changes that digit's segments mid-slot. No glitch beyond a single-cycle change is permitted, because every output is registered.

## Timing
- seg, dp and dig are registered from the current (cnt, idx, snapshot) state, giving a 1-cycle latency.
- The first clock edge after reset release registers cnt=0 (dead time). Digit 0 goes active at the 2nd edge.
- Load latency: data is sampled at edge N into the snapshot. It is visible on seg at edge N+1 if digit idx is active then.
- Full scan period: DIGITS*REFRESH_DIV clocks. Each digit is active REFRESH_DIV-1 clocks per period, separated by exactly 1 dead clock.
- Simultaneous load and cnt wrap: the new digit uses the new snapshot one cycle later. No special casing.

## Structure
- Package hex_display_pkg holds:
  - SEG_W=7;
  - the 16-entry segment constant table;
  - constants SEG_BLANK=7'b0000000 and MAX_DIGITS=8.
- Sub-module hex_seg_encode: purely combinational, 4-bit nibble in, 7-bit active-high segments out, driven from the package table. It is instantiated once, on the muxed nibble.
- The top level holds the prescaler, digit index, snapshot, blanking mask, polarity stage and output registers.
- An elaboration-time check rejects DIGITS outside 1..8 and REFRESH_DIV<2.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4, SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=1, BLANK_LEADING=1 unless stated otherwise.
1. **Reset.** Hold resetn=0 for 3 clocks -> dig=1111, seg=0000000, dp=0. Release -> 1 edge with dig=1111, then at the next edge dig=1110 and seg=1111110 (digit 0 shows "0").
2. **Full scan.** load data=16'h1A3F, dp_in=0000 -> over 16 clocks, exactly one dead cycle (dig=1111) per slot. The active slots show:
   - dig=1110 with seg=0111001
   - dig=1101 with seg=1001111
   - dig=1011 with seg=0111111
   - dig=0111 with seg=0000110
3. **Leading zeros.** load 16'h0007 -> digit 0 shows seg=0001110. Digits 1..3 are enabled in turn with seg=0000000. Then load 16'h0000 -> digit 0 shows 1111110 and the others are blank.
4. **Decimal points.** load 16'h1234 with dp_in=0100 -> dp=1 only while dig=1011, even when BLANK_LEADING=1 and data=0 would blank that digit.
5. **Tear-free update.** Change data with load=0 -> no output change over 2 full scans. Pulse load for 1 cycle during digit 0's slot -> seg updates at the next edge.
6. **Polarity / size variant.** DIGITS=1, SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=0. load 4'h8 -> seg=0000000 and dig=1 in active cycles. Dead cycle gives dig=0, seg=1111111.
